alu_issue_ctrl: RTL

- Multicycle issue/writeback controller for the 4-bit, 8-opcode combinational ALU.
- Holds a small register file and accepts one register-to-register instruction per valid/ready handshake.
- Reads the two source registers and presents them, with the opcode, on registered ALU inputs.
- Samples the ALU result one cycle later and writes it back to the destination register.

---
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multicycle issue/writeback controller for a 4-bit combinational ALU
// Accepts one reg-to-reg instruction per 3 cycles: IDLE (accept) -> EXEC (ALU settles) -> WB.
module alu_issue_ctrl #(
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_opcode,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  output logic [DATA_W-1:0] alu_ip1,
  output logic [DATA_W-1:0] alu_ip2,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_op,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_accept;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] r_ip1;
  logic [DATA_W-1:0] r_ip2;
  logic [2:0]        r_opcode;
  logic [ADDR_W-1:0] r_rd;
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_wb_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = ~rst;
        w_accept    = instr_valid;
        if (instr_valid) begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC:  w_next_state = S_WB;
      S_WB:    w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Accept reads use pre-edge register values, so a same-edge init write is not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_ip1      <= '0;
      r_ip2      <= '0;
      r_opcode   <= '0;
      r_rd       <= '0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_zero  <= 1'b1;
    end else begin
      r_wb_valid <= (r_state == S_EXEC);
      if (w_accept) begin
        r_ip1    <= r_regs[instr_rs1];
        r_ip2    <= r_regs[instr_rs2];
        r_opcode <= instr_opcode;
        r_rd     <= instr_rd;
      end
      if ((r_state == S_IDLE) && init_we) begin
        r_regs[init_addr] <= init_data;
      end
      if (r_state == S_EXEC) begin
        r_regs[r_rd] <= alu_op;
        r_wb_addr    <= r_rd;
        r_wb_data    <= alu_op;
        r_wb_zero    <= (alu_op == '0);
      end
    end
  end

  assign alu_ip1    = r_ip1;
  assign alu_ip2    = r_ip2;
  assign alu_opcode = r_opcode;
  assign wb_valid   = r_wb_valid;
  assign wb_addr    = r_wb_addr;
  assign wb_data    = r_wb_data;
  assign wb_zero    = r_wb_zero;
  assign dbg_data   = r_regs[dbg_addr];

endmodule
